// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG IDCODE reader.
//   state_e    : host-side sequencer states, one per group of TCK rising edges
//   TLR_CYCLES : TMS=1 edges used to force the target into Test-Logic-Reset
//   IDCODE_LEN : default IDCODE register length
//   tms_of()   : TMS level to present for the next rising edge of a state
package jtag_pkg;

   localparam int TLR_CYCLES = 5;
   localparam int IDCODE_LEN = 32;

   typedef enum logic [3:0] {
      IDLE,
      RST,
      RTI,
      SEL_DR,
      CAP_DR,
      SHIFT_ENTRY,
      SHIFT,
      UPDATE,
      IDLE_RTI,
      DONE
   } state_e;

   // last_bit only matters in SHIFT: the final data edge also leaves Shift-DR.
   function automatic logic tms_of(input state_e s, input logic last_bit);
      logic v;
      v = 1'b0;
      case (s)
         RST, SEL_DR, UPDATE: v = 1'b1;
         SHIFT:               v = last_bit;
         default:             v = 1'b0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: divides the system clock down to the JTAG test clock.
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   i_en           : run TCK; when low TCK is parked low and the divider cleared
//   o_tck          : JTAG test clock, toggles every CLK_DIV clk while enabled
//   o_rise         : high in the clk cycle whose closing edge takes TCK 0->1
//   o_fall         : high in the clk cycle whose closing edge takes TCK 1->0
module jtag_tck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_tck,
   output logic o_rise,
   output logic o_fall
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_tck;
   logic          w_wrap;

   assign w_wrap = i_en && (r_cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_tck <= 1'b0;
      end else if (!i_en) begin
         r_cnt <= '0;
         r_tck <= 1'b0;
      end else if (w_wrap) begin
         r_cnt <= '0;
         r_tck <= ~r_tck;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Strobes lead the TCK transition so the sequencer acts on the same clk edge.
   assign o_rise = w_wrap && !r_tck;
   assign o_fall = w_wrap &&  r_tck;
   assign o_tck  = r_tck;

endmodule

// File: rtl/jtag_id_reader.sv
// JTAG host-side initiator that reads a target's IDCODE.
// On start it walks the target TAP Test-Logic-Reset -> Run-Test/Idle ->
// Shift-DR, shifts DR_LEN bits of TDO in LSB first, then parks the target
// in Run-Test/Idle and presents the result.
//   clk, rst_n : system clock, asynchronous active-low reset
//   start      : one-cycle read request, ignored unless idle
//   busy       : transfer in progress
//   done       : one-cycle pulse when id_code/id_valid update
//   id_code    : captured IDCODE, bit 0 = first bit shifted out
//   id_valid   : id_code[0] (mandatory 1 for a real IDCODE)
//   tck/tms/tdi: JTAG outputs to target (tdi tied low)
//   tdo        : JTAG data from target
module jtag_id_reader
   import jtag_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int DR_LEN  = IDCODE_LEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [DR_LEN-1:0] id_code,
   output logic              id_valid,
   output logic              tck,
   output logic              tms,
   output logic              tdi,
   input  logic              tdo
);

   localparam int CW = $clog2(DR_LEN + 1);

   state_e            r_state, w_state_nxt;
   logic [CW-1:0]     r_bit, w_bit_nxt;
   logic              r_tms, w_tms_nxt;
   logic [DR_LEN-1:0] r_sr;
   logic [DR_LEN-1:0] r_id;
   logic              r_valid;
   logic              w_busy, w_rise, w_fall, w_start_ok;

   assign w_busy     = (r_state != IDLE) && (r_state != DONE);
   assign w_start_ok = (r_state == IDLE) && start;

   jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_en    (w_busy),
      .o_tck   (tck),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   // Each state covers the TCK rising edge(s) that use its TMS level. The
   // state advances on the falling edge after its last rising edge, so the
   // new TMS is launched while TCK is low and is stable for the next rise.
   // r_bit doubles as the TLR repeat counter in RST and the bit counter in SHIFT.
   always_comb begin
      w_state_nxt = r_state;
      w_bit_nxt   = r_bit;
      case (r_state)
         IDLE: if (start) begin
            w_state_nxt = RST;
            w_bit_nxt   = CW'(TLR_CYCLES - 1);
         end
         RST: if (w_fall) begin
            if (r_bit == '0) w_state_nxt = RTI;
            else             w_bit_nxt   = r_bit - 1'b1;
         end
         RTI:    if (w_fall) w_state_nxt = SEL_DR;
         SEL_DR: if (w_fall) w_state_nxt = CAP_DR;
         CAP_DR: if (w_fall) w_state_nxt = SHIFT_ENTRY;
         SHIFT_ENTRY: if (w_fall) begin
            w_state_nxt = SHIFT;
            w_bit_nxt   = CW'(DR_LEN - 1);
         end
         SHIFT: if (w_fall) begin
            if (r_bit == '0) w_state_nxt = UPDATE;
            else             w_bit_nxt   = r_bit - 1'b1;
         end
         UPDATE:   if (w_fall) w_state_nxt = IDLE_RTI;
         IDLE_RTI: if (w_fall) w_state_nxt = DONE;
         DONE:     w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
      w_tms_nxt = tms_of(w_state_nxt, w_bit_nxt == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_bit   <= '0;
         r_tms   <= 1'b1;
         r_sr    <= '0;
         r_id    <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_bit   <= w_bit_nxt;
         // TCK is parked low when a read is accepted, so raising TMS for the
         // reset sequence there is as safe as doing it on a falling edge.
         if (w_fall || w_start_ok)
            r_tms <= w_tms_nxt;
         if (w_rise && (r_state == SHIFT))
            r_sr <= {tdo, r_sr[DR_LEN-1:1]};
         if ((r_state == IDLE_RTI) && (w_state_nxt == DONE)) begin
            r_id    <= r_sr;
            r_valid <= r_sr[0];
         end
      end
   end

   assign busy     = w_busy;
   assign done     = (r_state == DONE);
   assign id_code  = r_id;
   assign id_valid = r_valid;
   assign tms      = r_tms;
   assign tdi      = 1'b0;

endmodule

// File: tb/tb_jtag_id_reader.sv
module tb_jtag_id_reader;

   localparam int DR    = 32;
   localparam int EDGES = 43;

   // IEEE 1149.1 TAP controller states for the target model
   localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                  PADR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10,
                  SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [2:0]    start;
   logic [2:0]    busy, done, id_valid, tck, tms, tdi;
   logic [2:0]    tdo = '0;
   logic [DR-1:0] id_a [3];

   function automatic int cd_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 2 : 5);
   endfunction

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         jtag_id_reader #(.CLK_DIV((g == 0) ? 1 : ((g == 1) ? 2 : 5)), .DR_LEN(DR)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .id_code  (id_a[g]),
            .id_valid (id_valid[g]),
            .tck      (tck[g]),
            .tms      (tms[g]),
            .tdi      (tdi[g]),
            .tdo      (tdo[g])
         );
      end
   endgenerate

   // ---------------- target: behavioural TAP + ID register ----------------
   function automatic int tap_next(input int s, input logic m);
      case (s)
         TLR:   return m ? TLR   : RTI;
         RTI:   return m ? SELDR : RTI;
         SELDR: return m ? SELIR : CAPDR;
         CAPDR: return m ? EX1DR : SHDR;
         SHDR:  return m ? EX1DR : SHDR;
         EX1DR: return m ? UPDR  : PADR;
         PADR:  return m ? EX2DR : PADR;
         EX2DR: return m ? UPDR  : SHDR;
         UPDR:  return m ? SELDR : RTI;
         SELIR: return m ? TLR   : CAPIR;
         CAPIR: return m ? EX1IR : SHIR;
         SHIR:  return m ? EX1IR : SHIR;
         EX1IR: return m ? UPIR  : PAIR;
         PAIR:  return m ? EX2IR : PAIR;
         EX2IR: return m ? UPIR  : SHIR;
         default: return m ? SELDR : RTI;
      endcase
   endfunction

   logic [DR-1:0] target_id [3];
   logic [DR-1:0] dr [3]       = '{'0, '0, '0};
   int            tap [3]      = '{RTI, RTI, RTI};
   int            rise_cnt [3] = '{0, 0, 0};
   int            done_cnt [3] = '{0, 0, 0};
   int            viol [3]     = '{0, 0, 0};
   int            per_err [3]  = '{0, 0, 0};
   int            runlen [3]   = '{0, 0, 0};
   logic [2:0]    prev_tck = '0, prev_tms = '1, first = '1, skip = '1;

   // TCK only moves on posedge clk (or async reset), so sampling on negedge
   // clk sees every TCK edge exactly once.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
         // TMS must never move while TCK is high; TDI must stay 0
         viol[k] <= viol[k] + int'((tms[k] != prev_tms[k]) && tck[k]) + int'(tdi[k] !== 1'b0);
         if (tck[k] != prev_tck[k]) begin
            runlen[k] <= 1;
            if (tck[k]) begin
               rise_cnt[k] <= rise_cnt[k] + 1;
               if (tap[k] == CAPDR)     dr[k] <= target_id[k];
               else if (tap[k] == SHDR) dr[k] <= {tdi[k], dr[k][DR-1:1]};
               tap[k] <= tap_next(tap[k], tms[k]);
               if (!first[k] && runlen[k] != cd_of(k)) per_err[k] <= per_err[k] + 1;
               first[k] <= 1'b0;
               skip[k]  <= 1'b0;
            end else begin
               if (!(skip[k] || !rst_n) && runlen[k] != cd_of(k)) per_err[k] <= per_err[k] + 1;
               if (tap[k] == SHDR) tdo[k] <= dr[k][0];
            end
         end else begin
            runlen[k] <= runlen[k] + 1;
         end
         if (!busy[k]) first[k] <= 1'b1;
         if (!rst_n)   skip[k]  <= 1'b1;
         prev_tck[k] <= tck[k];
         prev_tms[k] <= tms[k];
      end
   end

   // ---------------- checking ----------------
   int n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [DR-1:0] got, input logic [DR-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // mode 0: plain read; 1: extra starts at edge ~10 and in the DONE cycle;
   // 2: async reset part-way through the shift (returns right after checks)
   task automatic do_read(input int k, input logic [DR-1:0] id, input int mode);
      int rc0, dc0, v0, p0, lat, lim;
      bit seen, pulsed;
      target_id[k] = id;
      rc0 = rise_cnt[k]; dc0 = done_cnt[k]; v0 = viol[k]; p0 = per_err[k];
      lim = 2 * cd_of(k) * EDGES + 2;
      seen = 0; pulsed = 0; lat = 0;
      start[k] = 1'b1;
      for (int c = 1; c <= lim + 4 && !seen; c++) begin
         @(negedge clk);
         start[k] = 1'b0;
         if (mode == 1 && !pulsed && (rise_cnt[k] - rc0) >= 10) begin
            start[k] = 1'b1;
            pulsed   = 1;
         end
         if (mode == 2 && (rise_cnt[k] - rc0) >= 9 + 15) begin
            rst_n = 1'b0;
            #1;
            chk($sformatf("abort_tck[%0d]", k), tck[k], 0);
            chk($sformatf("abort_tms[%0d]", k), tms[k], 1);
            chk($sformatf("abort_busy[%0d]", k), busy[k], 0);
            chk($sformatf("abort_done[%0d]", k), done[k], 0);
            chk($sformatf("abort_id[%0d]", k), id_a[k], 0);
            chk($sformatf("abort_valid[%0d]", k), id_valid[k], 0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
         end
         if (done[k]) begin
            seen = 1;
            lat  = c;
         end
      end
      chk($sformatf("done_seen[%0d]", k), seen, 1);
      chk($sformatf("done_lat[%0d] lat=%0d", k, lat), seen && lat <= lim, 1);
      chk($sformatf("id_code[%0d]", k), id_a[k], id);
      chk($sformatf("id_valid[%0d]", k), id_valid[k], id[0]);
      if (mode == 1) start[k] = 1'b1;   // lands in the DONE cycle
      @(negedge clk);
      start[k] = 1'b0;
      repeat (4 * cd_of(k) + 4) @(negedge clk);
      chk($sformatf("tck_rises[%0d]", k), rise_cnt[k] - rc0, EDGES);
      chk($sformatf("done_pulses[%0d]", k), done_cnt[k] - dc0, 1);
      chk($sformatf("busy_after[%0d]", k), busy[k], 0);
      chk($sformatf("tap_rti[%0d]", k), tap[k], RTI);
      chk($sformatf("tms_parked[%0d]", k), tms[k], 0);
      chk($sformatf("proto_viol[%0d]", k), viol[k] - v0, 0);
      chk($sformatf("tck_period[%0d]", k), per_err[k] - p0, 0);
      chk($sformatf("id_hold[%0d]", k), id_a[k], id);
   endtask

   initial begin
      int bad;
      logic [DR-1:0] r;
      rst_n = 1'b0;
      start = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_tck", tck, 3'b000);
      chk("rst_tms", tms, 3'b111);
      chk("rst_busy", busy, 3'b000);
      chk("rst_done", done, 3'b000);
      chk("rst_id", id_a[1], 0);
      chk("rst_valid", id_valid, 3'b000);
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++)
            if (tck[k] !== 1'b0 || tms[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0 || id_a[k] !== '0)
               bad++;
      end
      chk("rst_hold_100", bad, 0);

      do_read(1, 32'h0000_0001, 0);
      do_read(1, 32'h1234_5679, 0);
      do_read(1, 32'hFFFF_FFFE, 0);
      do_read(1, 32'hFFFF_FFFF, 0);          // stuck-high TDO equivalent
      r = $urandom | 32'h1;
      do_read(1, r, 1);
      do_read(1, $urandom, 0);
      do_read(1, $urandom, 2);
      do_read(1, 32'h4BA0_0477, 0);

      r = $urandom;
      for (int k = 0; k < 3; k++) do_read(k, r, 0);
      for (int n = 0; n < 3; n++)
         for (int k = 0; k < 3; k++) do_read(k, $urandom, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
